// File: rtl/eq3_cam_pkg.sv
// Shared types and helpers for the 3-bit tag CAM: scan FSM states, tag width,
// and the group-counter width rule.
package eq3_cam_pkg;

  localparam int TAG_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cam_state_e;

  // The counter is never narrower than 1 bit, even when there is a single group.
  function automatic int grp_cnt_w(input int entries, input int lanes);
    return ((entries / lanes) > 1) ? $clog2(entries / lanes) : 1;
  endfunction

endpackage

// File: rtl/eq3_cam_scan_if.sv
// Write, search and result bundle of eq3_cam_scan; the slave side is the CAM.
// res_multi exists only when EQ3_CAM_MULTI_HIT_EN is defined.
interface eq3_cam_scan_if #(
  parameter int ENTRIES = 16
);
  import eq3_cam_pkg::*;

  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_vld;
  logic             srch_valid;
  logic             srch_ready;
  logic [TAG_W-1:0] srch_key;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [AW-1:0]    res_idx;
`ifdef EQ3_CAM_MULTI_HIT_EN
  logic             res_multi;
`endif

  modport master (
    output wr_en, wr_addr, wr_tag, wr_vld, srch_valid, srch_key, res_ready,
`ifdef EQ3_CAM_MULTI_HIT_EN
    input  res_multi,
`endif
    input  srch_ready, res_valid, res_hit, res_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_tag, wr_vld, srch_valid, srch_key, res_ready,
`ifdef EQ3_CAM_MULTI_HIT_EN
    output res_multi,
`endif
    output srch_ready, res_valid, res_hit, res_idx
  );

endinterface

// File: rtl/eq3_cam_group.sv
// One scan group: LANES eq_3 lanes gated by entry valid bits, lowest-lane
// priority encode; with EQ3_CAM_MULTI_HIT_EN also a per-group match count.
module eq3_cam_group
  import eq3_cam_pkg::*;
#(
  parameter int TARGET_CHIP = 1,
  parameter int LANES       = 4,
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CW         = $clog2(LANES + 1)
) (
  input  logic [TAG_W-1:0]            key,
  input  logic [LANES-1:0][TAG_W-1:0] tags,
  input  logic [LANES-1:0]            vld,
  output logic                        any_hit,
  output logic [LW-1:0]               lane
`ifdef EQ3_CAM_MULTI_HIT_EN
  ,
  output logic [CW-1:0]               cnt
`endif
);

  logic [LANES-1:0] eq;
  logic [LANES-1:0] hit;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    eq_3 #(.TARGET_CHIP(TARGET_CHIP)) u_eq (
      .a  (key),
      .b  (tags[l]),
      .eq (eq[l])
    );
  end

  assign hit     = eq & vld;
  assign any_hit = |hit;

  // Walk downward so the lowest hitting lane is the last one written.
  always_comb begin
    lane = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hit[l]) lane = LW'(l);
    end
  end

`ifdef EQ3_CAM_MULTI_HIT_EN
  always_comb begin
    cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      cnt = cnt + CW'(hit[l]);
    end
  end
`endif

endmodule

// File: rtl/eq_3.sv
// 3-bit equality comparator; TARGET_CHIP selects the mapping style, the
// function is identical on every family.
module eq_3 #(
  parameter int TARGET_CHIP = 1
) (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq
);

  generate
    if (TARGET_CHIP == 0) begin : g_generic
      assign eq = (a == b);
    end else begin : g_xnor
      assign eq = &(~(a ^ b));
    end
  endgenerate

endmodule

// File: rtl/eq3_cam_scan.sv
// 3-bit tag CAM scanned LANES entries per clock; lowest matching index on a
// valid/ready result port. EQ3_CAM_MULTI_HIT_EN: full scan plus res_multi.
module eq3_cam_scan
  import eq3_cam_pkg::*;
#(
  parameter int TARGET_CHIP = 1,
  parameter int ENTRIES     = 16,
  parameter int LANES       = 4
) (
  input logic           clk,
  input logic           sclr,
  eq3_cam_scan_if.slave bus
);

  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NG = ENTRIES / LANES;
  localparam int GW = grp_cnt_w(ENTRIES, LANES);
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]                        state;
  logic [GW-1:0]                     g;
  logic [TAG_W-1:0]                  key;
  logic [ENTRIES-1:0][TAG_W-1:0]     tags;
  logic [ENTRIES-1:0]                vld;
  logic [LANES-1:0][TAG_W-1:0]       grp_tags;
  logic [LANES-1:0]                  grp_vld;
  logic                              any_hit;
  logic [LW-1:0]                     lane;
  logic [AW-1:0]                     hit_idx;
  logic                              res_hit_q;
  logic [AW-1:0]                     res_idx_q;

  // Tag storage survives reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!sclr && bus.wr_en) tags[bus.wr_addr] <= bus.wr_tag;
  end

  always_ff @(posedge clk) begin
    if (sclr)            vld <= '0;
    else if (bus.wr_en)  vld[bus.wr_addr] <= bus.wr_vld;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      grp_tags[l] = tags[AW'(int'(g) * LANES + l)];
      grp_vld[l]  = vld[AW'(int'(g) * LANES + l)];
    end
  end

  assign hit_idx = AW'(int'(g) * LANES + int'(lane));

`ifdef EQ3_CAM_MULTI_HIT_EN
  logic [$clog2(LANES + 1)-1:0] cnt;
  logic                         found;
  logic [AW-1:0]                found_idx;
  logic [1:0]                   seen;
  logic [1:0]                   seen_nxt;
  logic                         res_multi_q;

  // Saturating match tally: only "none", "one" and "two or more" matter.
  always_comb begin
    seen_nxt = seen;
    if (int'(seen) + int'(cnt) >= 2) seen_nxt = 2'd2;
    else                             seen_nxt = 2'(int'(seen) + int'(cnt));
  end
`endif

  eq3_cam_group #(
    .TARGET_CHIP (TARGET_CHIP),
    .LANES       (LANES)
  ) u_group (
    .key     (key),
    .tags    (grp_tags),
    .vld     (grp_vld),
    .any_hit (any_hit),
    .lane    (lane)
`ifdef EQ3_CAM_MULTI_HIT_EN
    ,
    .cnt     (cnt)
`endif
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= ST_IDLE;
      g         <= '0;
      res_hit_q <= 1'b0;
      res_idx_q <= '0;
`ifdef EQ3_CAM_MULTI_HIT_EN
      res_multi_q <= 1'b0;
      found       <= 1'b0;
      found_idx   <= '0;
      seen        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.srch_valid) begin
            key   <= bus.srch_key;
            g     <= '0;
            state <= ST_SCAN;
`ifdef EQ3_CAM_MULTI_HIT_EN
            found <= 1'b0;
            seen  <= '0;
`endif
          end
        end
        ST_SCAN: begin
`ifdef EQ3_CAM_MULTI_HIT_EN
          seen <= seen_nxt;
          if (any_hit && !found) begin
            found     <= 1'b1;
            found_idx <= hit_idx;
          end
          if (g == G_LAST) begin
            res_hit_q   <= found | any_hit;
            res_idx_q   <= found ? found_idx : (any_hit ? hit_idx : '0);
            res_multi_q <= (seen_nxt == 2'd2);
            state       <= ST_DONE;
          end else begin
            g <= g + 1'b1;
          end
`else
          if (any_hit) begin
            res_hit_q <= 1'b1;
            res_idx_q <= hit_idx;
            state     <= ST_DONE;
          end else if (g == G_LAST) begin
            res_hit_q <= 1'b0;
            res_idx_q <= '0;
            state     <= ST_DONE;
          end else begin
            g <= g + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.srch_ready = (state == ST_IDLE);
  assign bus.res_valid  = (state == ST_DONE);
  assign bus.res_hit    = res_hit_q;
  assign bus.res_idx    = res_idx_q;
`ifdef EQ3_CAM_MULTI_HIT_EN
  assign bus.res_multi  = res_multi_q;
`endif

endmodule

// File: tb/tb_eq3_cam_scan.sv
// Scoreboard bench for eq3_cam_scan (ENTRIES=16, LANES=4); builds with or
// without EQ3_CAM_MULTI_HIT_EN and adapts its expectations accordingly.
module tb_eq3_cam_scan;

  localparam int ENTRIES = 16;
  localparam int LANES   = 4;
  localparam int NG      = ENTRIES / LANES;
`ifdef EQ3_CAM_MULTI_HIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  typedef struct {
    bit hit;
    int idx;
    bit multi;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  eq3_cam_scan_if #(.ENTRIES(ENTRIES)) bus ();

  eq3_cam_scan #(
    .TARGET_CHIP (1),
    .ENTRIES     (ENTRIES),
    .LANES       (LANES)
  ) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  exp_t       q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         rdy_mode    = 0;
  logic [2:0] m_tag[ENTRIES];
  bit         m_vld[ENTRIES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: scan the whole table in index order, then derive timing from
  // where the first match sits.
  function automatic exp_t predict(input logic [2:0] key);
    exp_t e;
    int   n = 0;
    e.hit = 1'b0; e.idx = 0; e.multi = 1'b0; e.acc = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_vld[i] && m_tag[i] == key) begin
        if (n == 0) e.idx = i;
        n++;
      end
    end
    e.hit   = (n > 0);
    e.multi = (n >= 2);
    e.lat   = (MULTI || !e.hit) ? NG : (e.idx / LANES + 1);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = 1'($urandom_range(0, 1));
      default: bus.res_ready = 1'b0;
    endcase
  end

  bit prev_vld     = 1'b0;
  bit chk_rdy_next = 1'b0;

  always @(negedge clk) begin
    if (sclr) begin
      prev_vld     = 1'b0;
      chk_rdy_next = 1'b0;
    end else begin
      if (chk_rdy_next) begin
        check("srch_ready_after_handshake", bus.srch_ready, 1);
        chk_rdy_next = 1'b0;
      end
      if (bus.res_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: res_valid=1 with no search outstanding, expected 0 (t=%0t)", $time);
        end else begin
          if (!prev_vld) check("latency", cyc - q[0].acc, q[0].lat);
          check("res_hit", bus.res_hit, q[0].hit);
          check("res_idx", bus.res_idx, q[0].idx);
`ifdef EQ3_CAM_MULTI_HIT_EN
          check("res_multi", bus.res_multi, q[0].multi);
`endif
          check("srch_ready_while_done", bus.srch_ready, 0);
          if (bus.res_ready) begin
            void'(q.pop_front());
            chk_rdy_next = 1'b1;
          end
        end
      end
      prev_vld = bus.res_valid && !bus.res_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [2:0] t, input bit v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_tag  = t;
    bus.wr_vld  = v;
    tick();
    bus.wr_en = 1'b0;
    m_tag[a]  = t;
    m_vld[a]  = v;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic search(input logic [2:0] key, input bit expect_res);
    exp_t e;
    int   n = 0;
    while (!bus.srch_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.srch_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL srch_ready_timeout: srch_ready=0, expected 1");
      return;
    end
    e = predict(key);
    bus.srch_valid = 1'b1;
    bus.srch_key   = key;
    tick();
    bus.srch_valid = 1'b0;
    e.acc = cyc;
    if (expect_res) q.push_back(e);
  endtask

  initial begin
    int n;
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_tag = '0; bus.wr_vld = 1'b0;
    bus.srch_valid = 1'b0; bus.srch_key = '0; bus.res_ready = 1'b1;
    sclr = 1'b1;
    tick();
    tick();
    sclr = 1'b0;

    check("reset_srch_ready", bus.srch_ready, 1);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_hit", bus.res_hit, 0);
    check("reset_res_idx", bus.res_idx, 0);
`ifdef EQ3_CAM_MULTI_HIT_EN
    check("reset_res_multi", bus.res_multi, 0);
`endif

    search(3'b101, 1'b1);
    wait_idle();

    wr(6, 3'b101, 1'b1);
    search(3'b101, 1'b1);
    wait_idle();

    wr(2, 3'b011, 1'b1);
    wr(9, 3'b011, 1'b1);
    search(3'b011, 1'b1);
    wait_idle();
    wr(2, 3'b011, 1'b0);
    search(3'b011, 1'b1);
    wait_idle();

    // Stall the consumer so the monitor sees the result held for several cycles.
    rdy_mode = 2;
    search(3'b101, 1'b1);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    rdy_mode = 0;
    wait_idle();

    // Abort a scan in group 1; the matching entry sits in group 3.
    wr(13, 3'b110, 1'b1);
    search(3'b110, 1'b0);
    tick();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    check("abort_srch_ready", bus.srch_ready, 1);
    check("abort_res_valid", bus.res_valid, 0);
    repeat (6) tick();
    search(3'b110, 1'b1);
    wait_idle();

    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        wr(int'($urandom_range(0, ENTRIES - 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
      end
      search(3'($urandom_range(0, 7)), 1'b1);
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
